// File: rtl/seq_timing_pkg.sv
// Shared definitions for the CPU sequence counter / timing decoder.
package seq_timing_pkg;

  // Default width of the sequence count and the matching number of timing lines.
  localparam int DEF_SEL_W = 3;
  localparam int DEF_OUT_N = 2 ** DEF_SEL_W;

  // Control-priority encoding, shared with the control-unit FSM.
  // Lower code means higher priority when several controls are asserted.
  typedef logic [2:0] prio_t;
  localparam prio_t P_RST  = 3'd0;
  localparam prio_t P_CLR  = 3'd1;
  localparam prio_t P_LD   = 3'd2;
  localparam prio_t P_EN   = 3'd3;
  localparam prio_t P_HOLD = 3'd4;

  // One-hot decode of a default-width select value.
  function automatic logic [DEF_OUT_N-1:0] onehot(input logic [DEF_SEL_W-1:0] sel);
    logic [DEF_OUT_N-1:0] y;
    y      = '0;
    y[sel] = 1'b1;
    return y;
  endfunction

endpackage

// File: rtl/seq_timing_decoder_onehot.sv
// Generalised N-way one-hot decoder with output enable (replaces a fixed 3-to-8).
module onehot_decoder #(
  parameter int SEL_W = 3
) (
  input  logic [SEL_W-1:0]      SEL,
  input  logic                  EN,
  output logic [2**SEL_W-1:0]   Y
);

  // Exactly one line high when enabled, all low otherwise.
  always_comb begin
    Y = '0;
    if (EN) begin
      Y[SEL] = 1'b1;
    end
  end

endmodule

// File: rtl/seq_timing_decoder.sv
// Sequence counter with fused one-hot timing decoder. Produces T[0..OUT_N-1]
// that step the control unit through fetch/decode/execute, with load, clear,
// hold, a wrap pulse and a rejected-load pulse.
module seq_timing_decoder
  import seq_timing_pkg::*;
#(
  parameter int SEL_W      = DEF_SEL_W,
  parameter int OUT_N      = 2 ** SEL_W,
  parameter int LAST_STATE = 2 ** SEL_W - 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             CLR,
  input  logic             LD,
  input  logic [SEL_W-1:0] LD_VAL,
  input  logic             DEC_EN,
  output logic [OUT_N-1:0] T,
  output logic [SEL_W-1:0] SC,
  output logic             WRAP,
  output logic             LD_ERR
);

  // Terminal count in counter width, and terminal+1 in increment width so the
  // wrap test never depends on SEL_W-bit overflow.
  localparam logic [SEL_W-1:0] LAST_V  = SEL_W'(LAST_STATE);
  localparam logic [SEL_W:0]   TERM_P1 = (SEL_W + 1)'(LAST_STATE + 1);

  logic [SEL_W-1:0] sc_q, sc_d;
  logic             wrap_q, wrap_d;
  logic             ld_err_q, ld_err_d;
  logic [SEL_W:0]   sc_inc;
  logic             at_last;
  logic             ld_ok;
  prio_t            ctrl;

  assign sc_inc  = {1'b0, sc_q} + {{SEL_W{1'b0}}, 1'b1};
  assign at_last = (sc_inc == TERM_P1);
  assign ld_ok   = (LD_VAL <= LAST_V);

  // Resolve simultaneous controls into a single winner: RST > CLR > LD > EN > hold.
  always_comb begin
    ctrl = P_HOLD;
    if (RST) begin
      ctrl = P_RST;
    end else if (CLR) begin
      ctrl = P_CLR;
    end else if (LD) begin
      ctrl = P_LD;
    end else if (EN) begin
      ctrl = P_EN;
    end
  end

  // Next-state mux for the count and the two single-cycle flags.
  always_comb begin
    sc_d     = sc_q;
    wrap_d   = 1'b0;
    ld_err_d = 1'b0;
    case (ctrl)
      P_RST: begin
        sc_d = '0;
      end
      P_CLR: begin
        // End-of-instruction clear; any simultaneous load is dropped silently.
        sc_d = '0;
      end
      P_LD: begin
        if (ld_ok) begin
          sc_d = LD_VAL;
        end else begin
          ld_err_d = 1'b1;
        end
      end
      P_EN: begin
        if (at_last) begin
          sc_d   = '0;
          wrap_d = 1'b1;
        end else begin
          sc_d = sc_inc[SEL_W-1:0];
        end
      end
      default: begin
        sc_d = sc_q;
      end
    endcase
  end

  // Count and flag registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sc_q     <= '0;
      wrap_q   <= 1'b0;
      ld_err_q <= 1'b0;
    end else begin
      sc_q     <= sc_d;
      wrap_q   <= wrap_d;
      ld_err_q <= ld_err_d;
    end
  end

  assign SC     = sc_q;
  assign WRAP   = wrap_q;
  assign LD_ERR = ld_err_q;

  // T is a pure decode of the registered count, gated by DEC_EN.
  onehot_decoder #(
    .SEL_W (SEL_W)
  ) u_dec (
    .SEL (sc_q),
    .EN  (DEC_EN),
    .Y   (T)
  );

endmodule

// File: tb/tb_seq_timing_decoder.sv
// Bench for seq_timing_decoder: three instances (LAST_STATE 7, 4, 0) share the
// same stimulus; a table of directed vectors, a back-to-back wrap sequence and
// a randomized run checked against a rule-level reference model.
module tb_seq_timing_decoder;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, clr, ld, dec_en;
  logic [2:0] ld_val;

  logic [7:0] t_a [3];
  logic [2:0] sc_a[3];
  logic       w_a [3];
  logic       e_a [3];

  seq_timing_decoder #(.SEL_W(3), .LAST_STATE(7)) dut7 (
    .CLK(clk), .RST(rst), .EN(en), .CLR(clr), .LD(ld), .LD_VAL(ld_val), .DEC_EN(dec_en),
    .T(t_a[0]), .SC(sc_a[0]), .WRAP(w_a[0]), .LD_ERR(e_a[0]));

  seq_timing_decoder #(.SEL_W(3), .LAST_STATE(4)) dut4 (
    .CLK(clk), .RST(rst), .EN(en), .CLR(clr), .LD(ld), .LD_VAL(ld_val), .DEC_EN(dec_en),
    .T(t_a[1]), .SC(sc_a[1]), .WRAP(w_a[1]), .LD_ERR(e_a[1]));

  seq_timing_decoder #(.SEL_W(3), .LAST_STATE(0)) dut0 (
    .CLK(clk), .RST(rst), .EN(en), .CLR(clr), .LD(ld), .LD_VAL(ld_val), .DEC_EN(dec_en),
    .T(t_a[2]), .SC(sc_a[2]), .WRAP(w_a[2]), .LD_ERR(e_a[2]));

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  bit armed    = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int lasts[3] = '{7, 4, 0};
  int m_sc[3];
  int m_wrap[3];
  int m_err[3];

  // Applies the per-edge rules to each instance's abstract state.
  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      int nsc, nw, ne;
      nsc = m_sc[i]; nw = 0; ne = 0;
      if (rst || clr) begin
        nsc = 0;
      end else if (ld) begin
        if (int'(ld_val) <= lasts[i]) nsc = int'(ld_val);
        else ne = 1;
      end else if (en) begin
        if (m_sc[i] == lasts[i]) begin nsc = 0; nw = 1; end
        else nsc = m_sc[i] + 1;
      end
      m_sc[i] = nsc; m_wrap[i] = nw; m_err[i] = ne;
    end
  endtask

  function automatic int exp_t(input int sc, input logic de);
    int r;
    r = de ? (1 << sc) : 0;
    return r;
  endfunction

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic check_model(input int i, input string tag);
    check($sformatf("%s_sc%0d", tag, lasts[i]), int'(sc_a[i]), m_sc[i]);
    check($sformatf("%s_t%0d", tag, lasts[i]), int'(t_a[i]), exp_t(m_sc[i], dec_en));
    check($sformatf("%s_wrap%0d", tag, lasts[i]), int'(w_a[i]), m_wrap[i]);
    check($sformatf("%s_lderr%0d", tag, lasts[i]), int'(e_a[i]), m_err[i]);
  endtask

  // Invariants on every cycle once out of power-on reset.
  always @(negedge clk) begin
    if (armed) begin
      for (int i = 0; i < 3; i++) begin
        if (dec_en) check($sformatf("onehot_t%0d", lasts[i]), int'($onehot(t_a[i])), 1);
        check($sformatf("sc_range%0d", lasts[i]), int'(int'(sc_a[i]) <= lasts[i]), 1);
      end
    end
  end

  // ---------------- directed vectors ----------------
  typedef struct {
    logic       rst, en, clr, ld;
    logic [2:0] ld_val;
    logic       dec;
    int         s7, w7, e7, s4, w4, e4;
  } vec_t;

  vec_t vecs[30];

  function automatic vec_t mk(input logic r, input logic e, input logic c, input logic l,
                              input int v, input logic d,
                              input int s7, input int w7, input int e7,
                              input int s4, input int w4, input int e4);
    vec_t x;
    x.rst = r; x.en = e; x.clr = c; x.ld = l; x.ld_val = 3'(v); x.dec = d;
    x.s7 = s7; x.w7 = w7; x.e7 = e7; x.s4 = s4; x.w4 = w4; x.e4 = e4;
    return x;
  endfunction

  initial begin
    //           rst en clr ld val dec   s7 w7 e7  s4 w4 e4
    vecs[0]  = mk(1, 0, 0, 0, 0, 1,      0, 0, 0,  0, 0, 0);  // reset
    vecs[1]  = mk(1, 0, 0, 0, 0, 1,      0, 0, 0,  0, 0, 0);
    vecs[2]  = mk(0, 0, 0, 0, 0, 0,      0, 0, 0,  0, 0, 0);  // T gated off
    vecs[3]  = mk(0, 1, 0, 0, 0, 1,      1, 0, 0,  1, 0, 0);  // count walk
    vecs[4]  = mk(0, 1, 0, 0, 0, 1,      2, 0, 0,  2, 0, 0);
    vecs[5]  = mk(0, 1, 0, 0, 0, 1,      3, 0, 0,  3, 0, 0);
    vecs[6]  = mk(0, 1, 0, 0, 0, 1,      4, 0, 0,  4, 0, 0);
    vecs[7]  = mk(0, 1, 0, 0, 0, 1,      5, 0, 0,  0, 1, 0);
    vecs[8]  = mk(0, 1, 0, 0, 0, 1,      6, 0, 0,  1, 0, 0);
    vecs[9]  = mk(0, 1, 0, 0, 0, 1,      7, 0, 0,  2, 0, 0);
    vecs[10] = mk(0, 1, 0, 0, 0, 1,      0, 1, 0,  3, 0, 0);
    vecs[11] = mk(0, 1, 0, 0, 0, 1,      1, 0, 0,  4, 0, 0);
    vecs[12] = mk(0, 0, 0, 1, 3, 1,      3, 0, 0,  3, 0, 0);  // load 3
    vecs[13] = mk(0, 0, 0, 1, 6, 1,      6, 0, 0,  3, 0, 1);  // load 6
    vecs[14] = mk(0, 0, 0, 0, 0, 1,      6, 0, 0,  3, 0, 0);  // hold
    vecs[15] = mk(0, 1, 0, 1, 5, 1,      5, 0, 0,  3, 0, 1);  // LD beats EN
    vecs[16] = mk(0, 1, 1, 1, 2, 1,      0, 0, 0,  0, 0, 0);  // CLR+LD+EN
    vecs[17] = mk(0, 1, 0, 1, 2, 1,      2, 0, 0,  2, 0, 0);  // LD+EN
    vecs[18] = mk(0, 1, 0, 0, 0, 1,      3, 0, 0,  3, 0, 0);
    vecs[19] = mk(0, 1, 0, 0, 0, 1,      4, 0, 0,  4, 0, 0);
    vecs[20] = mk(0, 1, 0, 0, 0, 1,      5, 0, 0,  0, 1, 0);
    vecs[21] = mk(0, 1, 0, 0, 0, 1,      6, 0, 0,  1, 0, 0);
    vecs[22] = mk(1, 1, 0, 0, 0, 1,      0, 0, 0,  0, 0, 0);  // mid-run reset
    vecs[23] = mk(0, 1, 0, 0, 0, 1,      1, 0, 0,  1, 0, 0);
    vecs[24] = mk(0, 1, 0, 0, 0, 1,      2, 0, 0,  2, 0, 0);
    vecs[25] = mk(0, 0, 0, 1, 7, 1,      7, 0, 0,  2, 0, 1);  // load 7
    vecs[26] = mk(0, 1, 0, 0, 0, 0,      0, 1, 0,  3, 0, 0);
    vecs[27] = mk(0, 0, 0, 1, 7, 1,      7, 0, 0,  3, 0, 1);
    vecs[28] = mk(0, 1, 1, 0, 0, 1,      0, 0, 0,  0, 0, 0);  // clear at terminal
    vecs[29] = mk(0, 0, 0, 0, 0, 1,      0, 0, 0,  0, 0, 0);

    rst = 1'b1; en = 1'b0; clr = 1'b0; ld = 1'b0; ld_val = '0; dec_en = 1'b1;
    for (int i = 0; i < 3; i++) begin m_sc[i] = 0; m_wrap[i] = 0; m_err[i] = 0; end

    for (int v = 0; v < 30; v++) begin
      rst = vecs[v].rst; en = vecs[v].en; clr = vecs[v].clr; ld = vecs[v].ld;
      ld_val = vecs[v].ld_val; dec_en = vecs[v].dec;
      step();
      armed = 1'b1;
      check($sformatf("v%0d_sc7", v),   int'(sc_a[0]), vecs[v].s7);
      check($sformatf("v%0d_t7", v),    int'(t_a[0]),  exp_t(vecs[v].s7, vecs[v].dec));
      check($sformatf("v%0d_wrap7", v), int'(w_a[0]),  vecs[v].w7);
      check($sformatf("v%0d_err7", v),  int'(e_a[0]),  vecs[v].e7);
      check($sformatf("v%0d_sc4", v),   int'(sc_a[1]), vecs[v].s4);
      check($sformatf("v%0d_t4", v),    int'(t_a[1]),  exp_t(vecs[v].s4, vecs[v].dec));
      check($sformatf("v%0d_wrap4", v), int'(w_a[1]),  vecs[v].w4);
      check($sformatf("v%0d_err4", v),  int'(e_a[1]),  vecs[v].e4);
    end

    // Back-to-back wraps on the single-state counter keep WRAP high.
    rst = 1'b1; en = 1'b0; clr = 1'b0; ld = 1'b0; dec_en = 1'b1;
    step();
    rst = 1'b0; en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("b2b%0d_wrap0", k), int'(w_a[2]), 1);
      check($sformatf("b2b%0d_sc0", k), int'(sc_a[2]), 0);
      check($sformatf("b2b%0d_t0", k), int'(t_a[2]), 1);
    end
    en = 1'b0;
    step();
    check("b2b_end_wrap0", int'(w_a[2]), 0);

    // Randomized run against the reference model.
    for (int n = 0; n < 2000; n++) begin
      rst    = ($urandom_range(0, 49) == 0);
      clr    = ($urandom_range(0, 19) == 0);
      ld     = ($urandom_range(0, 9) == 0);
      en     = ($urandom_range(0, 9) < 7);
      ld_val = 3'($urandom_range(0, 7));
      dec_en = ($urandom_range(0, 3) != 0);
      step();
      for (int i = 0; i < 3; i++) check_model(i, "rnd");
    end

    armed = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
